// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: ID-side control inputs, instruction memory port and IF/ID outputs.
// The slave modport is the fetch stage; the master modport is the ID/memory side.
interface fetch_stage_if;
    logic        stall;
    logic        branch_taken;
    logic        jump_taken;
    logic [31:0] branch_offset;
    logic [31:0] jump_address;
    logic        terminate;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] id_pc_plus1;
    logic        halted;
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;

    modport slave (
        input  stall,
        input  branch_taken,
        input  jump_taken,
        input  branch_offset,
        input  jump_address,
        input  terminate,
        input  imem_data,
        output imem_addr,
        output pc,
        output instruction,
        output id_pc_plus1,
        output halted,
        output fetch_count,
        output bubble_count
    );

    modport master (
        output stall,
        output branch_taken,
        output jump_taken,
        output branch_offset,
        output jump_address,
        output terminate,
        output imem_data,
        input  imem_addr,
        input  pc,
        input  instruction,
        input  id_pc_plus1,
        input  halted,
        input  fetch_count,
        input  bubble_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: word-addressed PC, IF/ID register, terminate drain sequencing.
// Optional perf counters enabled by defining FETCH_PERF_COUNTERS_EN.
//
// state  | meaning
// RUN    | normal fetch; stall holds, redirects squash IF/ID with a NOP
// DRAIN  | terminate seen; PC frozen, 3 cycles to empty EX/MEM/WB
// HALTED | pipeline empty; everything frozen until rst
module fetch_stage (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] r_pc_plus1;
    logic [31:0] w_pc_plus1_nxt;
    logic [1:0]  r_drain_cnt;
    logic [1:0]  w_drain_cnt_nxt;
    logic        r_halted;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_instr_nxt     = r_instr;
        w_pc_plus1_nxt  = r_pc_plus1;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            RUN: begin
                if (!bus.stall) begin
                    if (bus.terminate) begin
                        w_instr_nxt     = 32'd0;
                        w_pc_plus1_nxt  = 32'd0;
                        w_drain_cnt_nxt = 2'd3;
                        w_state_nxt     = DRAIN;
                    end else if (bus.jump_taken) begin
                        w_pc_nxt       = bus.jump_address;
                        w_instr_nxt    = 32'd0;
                        w_pc_plus1_nxt = 32'd0;
                    end else if (bus.branch_taken) begin
                        // Branch target is relative to the instruction sitting in ID.
                        w_pc_nxt       = r_pc_plus1 + bus.branch_offset;
                        w_instr_nxt    = 32'd0;
                        w_pc_plus1_nxt = 32'd0;
                    end else begin
                        w_instr_nxt    = bus.imem_data;
                        w_pc_plus1_nxt = r_pc + 32'd1;
                        w_pc_nxt       = r_pc + 32'd1;
                    end
                end
            end
            DRAIN: begin
                w_drain_cnt_nxt = r_drain_cnt - 2'd1;
                if (r_drain_cnt <= 2'd1) begin
                    w_drain_cnt_nxt = 2'd0;
                    w_state_nxt     = HALTED;
                end
            end
            HALTED: begin
                w_state_nxt = HALTED;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_pc        <= 32'd0;
            r_instr     <= 32'd0;
            r_pc_plus1  <= 32'd0;
            r_drain_cnt <= 2'd0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_instr     <= w_instr_nxt;
            r_pc_plus1  <= w_pc_plus1_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_halted    <= (w_state_nxt == HALTED);
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_bubble_count;
    logic        w_run;
    logic        w_fetch_en;
    logic        w_bubble_en;

    assign w_run       = (r_state == RUN);
    assign w_fetch_en  = w_run && !bus.stall && !bus.terminate
                         && !bus.jump_taken && !bus.branch_taken;
    assign w_bubble_en = w_run && (bus.stall || bus.terminate
                         || bus.jump_taken || bus.branch_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count  <= 32'd0;
            r_bubble_count <= 32'd0;
        end else begin
            if (w_fetch_en) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_bubble_en) begin
                r_bubble_count <= r_bubble_count + 32'd1;
            end
        end
    end

    assign bus.fetch_count  = r_fetch_count;
    assign bus.bubble_count = r_bubble_count;
`else
    assign bus.fetch_count  = 32'd0;
    assign bus.bubble_count = 32'd0;
`endif

    assign bus.imem_addr   = r_pc;
    assign bus.pc          = r_pc;
    assign bus.instruction = r_instr;
    assign bus.id_pc_plus1 = r_pc_plus1;
    assign bus.halted      = r_halted;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage; imem model returns 0x20000000 + address.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    fetch_stage_if bus();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = 32'h2000_0000 + bus.imem_addr;

    typedef struct {
        logic        stall;
        logic        br;
        logic        jmp;
        logic        term;
        logic [31:0] off;
        logic [31:0] addr;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic [31:0] e_pc1;
        logic        e_halt;
        logic [31:0] e_fc;
        logic [31:0] e_bc;
    } vec_t;

    vec_t tv[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef FETCH_PERF_COUNTERS_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic drive(input logic s, input logic b, input logic j, input logic t,
                         input logic [31:0] off, input logic [31:0] addr);
        bus.stall         = s;
        bus.branch_taken  = b;
        bus.jump_taken    = j;
        bus.terminate     = t;
        bus.branch_offset = off;
        bus.jump_address  = addr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [31:0] pc1, input logic h,
                             input logic [31:0] fc, input logic [31:0] bc);
        chk({tag, " pc"}, bus.pc, pc);
        chk({tag, " imem_addr"}, bus.imem_addr, pc);
        chk({tag, " instruction"}, bus.instruction, ins);
        chk({tag, " id_pc_plus1"}, bus.id_pc_plus1, pc1);
        chk({tag, " halted"}, {31'd0, bus.halted}, {31'd0, h});
        chk({tag, " fetch_count"}, bus.fetch_count, perf(fc));
        chk({tag, " bubble_count"}, bus.bubble_count, perf(bc));
    endtask

    initial begin
        //          stall br  jmp term off            addr           pc            ins            pc1          halt fc     bc
        tv[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'd1,        32'h2000_0000, 32'd1,      1'b0,32'd1, 32'd0};
        tv[1]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'd2,        32'h2000_0001, 32'd2,      1'b0,32'd2, 32'd0};
        tv[2]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'd3,        32'h2000_0002, 32'd3,      1'b0,32'd3, 32'd0};
        tv[3]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'd4,        32'h2000_0003, 32'd4,      1'b0,32'd4, 32'd0};
        tv[4]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'd5,        32'h2000_0004, 32'd5,      1'b0,32'd5, 32'd0};
        tv[5]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'd5,        32'h2000_0004, 32'd5,      1'b0,32'd5, 32'd1};
        tv[6]  = '{1'b1,1'b1,1'b1,1'b1,32'h10,       32'h80,       32'd5,        32'h2000_0004, 32'd5,      1'b0,32'd5, 32'd2};
        tv[7]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'd6,        32'h2000_0005, 32'd6,      1'b0,32'd6, 32'd2};
        tv[8]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'd7,        32'h2000_0006, 32'd7,      1'b0,32'd7, 32'd2};
        tv[9]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'd8,        32'h2000_0007, 32'd8,      1'b0,32'd8, 32'd2};
        tv[10] = '{1'b0,1'b1,1'b0,1'b0,32'hFFFF_FFFC,32'h0,        32'd4,        32'h0,         32'd0,      1'b0,32'd8, 32'd3};
        tv[11] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'd5,        32'h2000_0004, 32'd5,      1'b0,32'd9, 32'd3};
        tv[12] = '{1'b0,1'b1,1'b1,1'b0,32'h100,      32'h40,       32'h40,       32'h0,         32'd0,      1'b0,32'd9, 32'd4};
        tv[13] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h41,       32'h2000_0040, 32'h41,     1'b0,32'd10,32'd4};
        tv[14] = '{1'b0,1'b1,1'b0,1'b0,32'h2,        32'h0,        32'h43,       32'h0,         32'd0,      1'b0,32'd10,32'd5};
        tv[15] = '{1'b0,1'b1,1'b0,1'b0,32'hA,        32'h0,        32'd10,       32'h0,         32'd0,      1'b0,32'd10,32'd6};
        tv[16] = '{1'b0,1'b1,1'b1,1'b1,32'h5,        32'h80,       32'd10,       32'h0,         32'd0,      1'b0,32'd10,32'd7};
        tv[17] = '{1'b0,1'b0,1'b1,1'b0,32'h0,        32'h80,       32'd10,       32'h0,         32'd0,      1'b0,32'd10,32'd7};
        tv[18] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'd10,       32'h0,         32'd0,      1'b0,32'd10,32'd7};
        tv[19] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'd10,       32'h0,         32'd0,      1'b1,32'd10,32'd7};
        tv[20] = '{1'b0,1'b1,1'b1,1'b0,32'h3,        32'h80,       32'd10,       32'h0,         32'd0,      1'b1,32'd10,32'd7};

        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        chk_state("reset", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive(tv[i].stall, tv[i].br, tv[i].jmp, tv[i].term, tv[i].off, tv[i].addr);
            step();
            chk_state($sformatf("vec%0d", i), tv[i].e_pc, tv[i].e_ins, tv[i].e_pc1,
                      tv[i].e_halt, tv[i].e_fc, tv[i].e_bc);
        end

        // reset out of HALTED
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h7, 32'h99);
        rst = 1'b1;
        step();
        chk_state("rst_halted", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;

        // PC wrap at 0xFFFFFFFF
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF);
        step();
        chk_state("jump_top", 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 32'd0, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk_state("wrap", 32'd0, 32'h1FFF_FFFF, 32'd0, 1'b0, 32'd1, 32'd1);

        // reset asserted mid-DRAIN
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        step();
        chk_state("drain1", 32'd0, 32'd0, 32'd0, 1'b0, 32'd1, 32'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk_state("drain2", 32'd0, 32'd0, 32'd0, 1'b0, 32'd1, 32'd2);
        rst = 1'b1;
        step();
        chk_state("rst_drain", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        step();
        chk_state("resume1", 32'd1, 32'h2000_0000, 32'd1, 1'b0, 32'd1, 32'd0);
        step();
        chk_state("resume2", 32'd2, 32'h2000_0001, 32'd2, 1'b0, 32'd2, 32'd0);
        step();
        step();
        step();
        chk_state("no_halt", 32'd5, 32'h2000_0004, 32'd5, 1'b0, 32'd5, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have ports (clock and reset first); one clock; reset is synchronous and active-high.
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard hold from ID; freeze PC and IF/ID register
- branch_taken  in  1  ID resolved conditional branch taken
- jump_taken  in  1  ID resolved j/jal/jr
- branch_offset  in  32  signed word offset from ID
- jump_address  in  32  absolute word-address jump target from ID
- terminate  in  1  ID decoded halt instruction
- imem_data  in  32  instruction word; combinational read of imem_addr
- imem_addr  out  32  word address to instruction memory (= pc)
- pc  out  32  current fetch PC, word-addressed
- instruction  out  32  IF/ID register: instruction presented to ID
- id_pc_plus1  out  32  IF/ID register: fetch PC + 1 of that instruction
- halted  out  1  pipeline drained after terminate
- fetch_count  out  32  perf counter (see Configuration)
- bubble_count  out  32  perf counter (see Configuration)

Function
REQ-002 SHALL keep PC in 32-bit word units; all arithmetic mod 2^32 (wrap from 0xFFFFFFFF to 0, no flag).
REQ-003 SHALL drive imem_addr = pc combinationally; fetch latency one cycle (imem_data captured into IF/ID at the next rising edge).
REQ-004 State machine states RUN, DRAIN, HALTED.
REQ-005 RUN, stall=1: pc, instruction, id_pc_plus1 SHALL hold; branch_taken/jump_taken/terminate ignored that cycle.
REQ-006 RUN, stall=0, jump_taken=1: pc <= jump_address; instruction <= 0 (NOP squash); id_pc_plus1 <= 0.
REQ-007 RUN, stall=0, branch_taken=1, jump_taken=0: pc <= id_pc_plus1 + branch_offset; instruction <= 0; id_pc_plus1 <= 0.
REQ-008 jump_taken SHALL have priority over branch_taken when both are 1.
REQ-009 RUN, stall=0, no redirect, no terminate: instruction <= imem_data; id_pc_plus1 <= pc + 1; pc <= pc + 1.
REQ-010 RUN, stall=0, terminate=1: takes priority over redirects; pc holds; instruction <= 0; id_pc_plus1 <= 0; drain counter <= 3; state <= DRAIN.
REQ-011 DRAIN: pc holds; IF/ID keeps NOP; all ID inputs ignored; counter decrements each cycle; at counter==1 state <= HALTED on the next edge (exactly 3 cycles in DRAIN, covering EX, MEM, WB).
REQ-012 HALTED: all registers hold; halted=1; only rst exits.
REQ-013 halted SHALL be 1 only in HALTED; registered, no combinational path from inputs.

Reset
REQ-014 On rising clk with rst=1: pc=0, instruction=0, id_pc_plus1=0, state=RUN, drain counter=0, halted=0, fetch_count=0, bubble_count=0.
REQ-015 rst SHALL override every other input, including mid-DRAIN and in HALTED; fetch resumes from address 0 on the first edge after rst falls.

Configuration
REQ-016 Macro FETCH_PERF_COUNTERS_EN: when defined, fetch_count increments on every REQ-009 capture and bubble_count increments on every cycle in RUN where a NOP is loaded (REQ-006/007/010) or stall=1; both 32-bit, wrapping, frozen in DRAIN/HALTED.
REQ-017 Without FETCH_PERF_COUNTERS_EN: ports remain present, tied to constant 0, no counter flops synthesized; all other behaviour identical.

Verification
REQ-018 Bench SHALL cover:
- Reset then 4 cycles, imem[n]=0x20000000+n, no stall -> pc 0,1,2,3,4; instruction 0x20000000..0x20000003; id_pc_plus1 1..4.
- stall=1 for 2 cycles at pc=5 -> pc, instruction, id_pc_plus1 unchanged; bubble_count +2 (macro on).
- id_pc_plus1=8, branch_taken=1, branch_offset=0xFFFFFFFC -> pc=4, instruction=0 next cycle.
- jump_taken=1 and branch_taken=1 together, jump_address=0x40 -> pc=0x40 (jump wins).
- terminate=1 at pc=10 -> pc stays 10, halted=0 for 3 cycles then 1; rst asserted mid-DRAIN -> pc=0, halted=0, state RUN.
- pc=0xFFFFFFFF, no stall -> pc=0 next cycle; id_pc_plus1=0.
